// File: rtl/sram_controller.sv
// 32-bit word access to a 16-bit asynchronous SRAM as two halfword cycles.
// Optional macro SRAM_WAIT_STATES_EN inserts WAIT1/WAIT2 after the HIGH halfword.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT1, WAIT2, DONE} state_e;

  state_e      state_q;
  logic [16:0] index_q;
  logic [15:0] dataHigh_q;
  logic        isWrite_q;
  logic [31:0] readData_q;
  logic [17:0] sramAddr_q;
  logic        weN_q;
  logic        dqOe_q;
  logic [15:0] dqOut_q;

  logic        request;
  logic [16:0] index_d;

  assign request = wr_en | rd_en;
  assign index_d = 17'((address - BASE_ADDR) >> 2);

  // Strobe, bus drive and address are set one state ahead so they are
  // already stable for the whole LOW/HIGH cycle they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      index_q    <= '0;
      dataHigh_q <= '0;
      isWrite_q  <= 1'b0;
      readData_q <= '0;
      sramAddr_q <= '0;
      weN_q      <= 1'b1;
      dqOe_q     <= 1'b0;
      dqOut_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (request) begin
            index_q    <= index_d;
            dataHigh_q <= write_data[31:16];
            isWrite_q  <= wr_en;
            sramAddr_q <= {index_d, 1'b0};
            weN_q      <= ~wr_en;
            dqOe_q     <= wr_en;
            dqOut_q    <= write_data[15:0];
            state_q    <= LOW;
          end
        end
        LOW: begin
          if (!isWrite_q) readData_q[15:0] <= SRAM_DQ;
          sramAddr_q <= {index_q, 1'b1};
          dqOut_q    <= dataHigh_q;
          state_q    <= HIGH;
        end
        HIGH: begin
          if (!isWrite_q) readData_q[31:16] <= SRAM_DQ;
          weN_q  <= 1'b1;
          dqOe_q <= 1'b0;
`ifdef SRAM_WAIT_STATES_EN
          state_q <= WAIT1;
`else
          state_q <= DONE;
`endif
        end
        WAIT1:   state_q <= WAIT2;
        WAIT2:   state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = ((state_q == IDLE) && !request) || (state_q == DONE);
  assign read_data = readData_q;
  assign SRAM_ADDR = sramAddr_q;
  assign SRAM_WE_N = weN_q;
  assign SRAM_DQ   = dqOe_q ? dqOut_q : 16'bz;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural SRAM model.
// Expected latency follows SRAM_WAIT_STATES_EN.
module tb_sram_controller;

`ifdef SRAM_WAIT_STATES_EN
  localparam int EXP_LAT = 5;
`else
  localparam int EXP_LAT = 3;
`endif

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;

  int total;
  int bad;

  logic [15:0] mem [0:255];
  logic        memDrive;

  sram_controller dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: drives the bus whenever not strobed for write, latches on WE_N low
  assign SRAM_DQ = (memDrive && SRAM_WE_N) ? mem[SRAM_ADDR[7:0]] : 16'bz;

  always @(negedge clk) begin
    if (!SRAM_WE_N) mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one request from an IDLE negedge and holds it until ready=1 (DONE)
  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] addr,
                               input logic [31:0] data, output int lat, output int weCnt,
                               output int dqHits, output logic [17:0] aLow,
                               output logic [17:0] aHigh);
    bit done;
    @(negedge clk);
    wr_en = w; rd_en = r; address = addr; write_data = data;
    lat = 0; weCnt = 0; dqHits = 0; aLow = '0; aHigh = '0; done = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!SRAM_WE_N) weCnt++;
      if (!memDrive && (SRAM_DQ === 16'hFFFF)) dqHits++;
      if (i == 1) aLow = SRAM_ADDR;
      if (i == 2) aHigh = SRAM_ADDR;
      if (ready) begin
        done = 1;
        break;
      end
      lat++;
      @(negedge clk);
    end
    checkOutput("timeout", {31'd0, done}, 32'd1);
    wr_en = 0; rd_en = 0;
  endtask

  int lat, weCnt, dqHits;
  logic [17:0] aLow, aHigh;

  initial begin
    total = 0; bad = 0;
    memDrive = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst = 1'b0; wr_en = 0; rd_en = 0; address = 0; write_data = 0;
    repeat (2) @(negedge clk);
    checkOutput("rstReady", {31'd0, ready}, 32'd1);
    checkOutput("rstWeN", {31'd0, SRAM_WE_N}, 32'd1);
    checkOutput("rstAddr", {14'd0, SRAM_ADDR}, 32'd0);
    checkOutput("rstRdata", read_data, 32'd0);
    rst = 1'b1;

    // write 0xDEADBEEF at word 0
    applyStimulus(1, 0, 32'd1024, 32'hDEADBEEF, lat, weCnt, dqHits, aLow, aHigh);
    checkOutput("wrLat", lat, EXP_LAT);
    checkOutput("wrWe", weCnt, 2);
    checkOutput("wrMem0", {16'd0, mem[0]}, 32'h0000BEEF);
    checkOutput("wrMem1", {16'd0, mem[1]}, 32'h0000DEAD);

    applyStimulus(0, 1, 32'd1024, 32'h0, lat, weCnt, dqHits, aLow, aHigh);
    checkOutput("rdLat", lat, EXP_LAT);
    checkOutput("rdWe", weCnt, 0);
    checkOutput("rdData", read_data, 32'hDEADBEEF);

    // read with the SRAM silent: the controller must never drive write_data onto the bus
    memDrive = 1'b0;
    applyStimulus(0, 1, 32'd1024, 32'hFFFFFFFF, lat, weCnt, dqHits, aLow, aHigh);
    checkOutput("rdNoDrive", dqHits, 0);
    memDrive = 1'b1;

    // back-to-back write then read at 1028
    applyStimulus(1, 0, 32'd1028, 32'h12345678, lat, weCnt, dqHits, aLow, aHigh);
    checkOutput("b2bAddrLo", {14'd0, aLow}, 32'd2);
    checkOutput("b2bAddrHi", {14'd0, aHigh}, 32'd3);
    applyStimulus(0, 1, 32'd1028, 32'h0, lat, weCnt, dqHits, aLow, aHigh);
    checkOutput("b2bRdLat", lat, EXP_LAT);
    checkOutput("b2bRdAddrLo", {14'd0, aLow}, 32'd2);
    checkOutput("b2bData", read_data, 32'h12345678);

    // both requests: write wins, read_data untouched
    applyStimulus(1, 1, 32'd1032, 32'h0000A5A5, lat, weCnt, dqHits, aLow, aHigh);
    checkOutput("bothWe", weCnt, 2);
    checkOutput("bothMem4", {16'd0, mem[4]}, 32'h0000A5A5);
    checkOutput("bothMem5", {16'd0, mem[5]}, 32'h00000000);
    checkOutput("bothRdata", read_data, 32'h12345678);

    // round trip at 1040
    applyStimulus(1, 0, 32'd1040, 32'hCAFEF00D, lat, weCnt, dqHits, aLow, aHigh);
    checkOutput("rtWrLat", lat, EXP_LAT);
    applyStimulus(0, 1, 32'd1040, 32'h0, lat, weCnt, dqHits, aLow, aHigh);
    checkOutput("rtRdLat", lat, EXP_LAT);
    checkOutput("rtData", read_data, 32'hCAFEF00D);

    // address below BASE_ADDR wraps to the top word
    applyStimulus(1, 0, 32'd1020, 32'h11112222, lat, weCnt, dqHits, aLow, aHigh);
    checkOutput("wrapAddrLo", {14'd0, aLow}, 32'h0003FFFE);
    checkOutput("wrapAddrHi", {14'd0, aHigh}, 32'h0003FFFF);

    // reset during HIGH of a write
    @(negedge clk);
    wr_en = 1; address = 32'd1024; write_data = 32'h55667788;
    repeat (2) @(negedge clk);
    checkOutput("preRstWeN", {31'd0, SRAM_WE_N}, 32'd0);
    rst = 1'b0; wr_en = 0;
    #1;
    checkOutput("midRstWeN", {31'd0, SRAM_WE_N}, 32'd1);
    checkOutput("midRstReady", {31'd0, ready}, 32'd1);
    checkOutput("midRstAddr", {14'd0, SRAM_ADDR}, 32'd0);
    checkOutput("midRstRdata", read_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("postRstReady", {31'd0, ready}, 32'd1);
    checkOutput("postRstWeN", {31'd0, SRAM_WE_N}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter BASE_ADDR, default 1024, is the byte address of data-memory word 0 and SHALL be subtracted from every request address.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 wr_en  input  1  write request from the MEM stage; held until ready=1.
REQ-006 rd_en  input  1  read request from the MEM stage; held until ready=1.
REQ-007 address  input  32  byte address from the ALU result.
REQ-008 write_data  input  32  store data (Val_Rm).
REQ-009 read_data  output  32  load data; valid while ready=1 at the end of a read.
REQ-010 ready  output  1  pipeline freeze is ~ready.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  output  18  SRAM halfword address.
REQ-013 SRAM_WE_N  output  1  active-low write strobe.
REQ-014 SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  tied 0.

Function
REQ-015 The word index SHALL be ((address - BASE_ADDR) >> 2) truncated to 17 bits; out-of-range addresses wrap modulo 2^17 words.
REQ-016 The low halfword SHALL be at SRAM_ADDR = {index, 1'b0}, and the high halfword at {index, 1'b1}.
REQ-017 FSM states SHALL be IDLE, LOW, HIGH, WAIT1, WAIT2, DONE.
- IDLE→LOW on any request.
- LOW→HIGH→WAIT1→WAIT2→DONE unconditionally.
- DONE→IDLE unconditionally.
REQ-018 In IDLE, when a request is present, the block SHALL latch address, write_data and the operation type; wr_en has priority if both are asserted.
REQ-019 ready SHALL be combinational:
- 1 in IDLE with no request.
- 1 in DONE.
- 0 otherwise, including IDLE with a request present.
REQ-020 A request SHALL see ready=0 for exactly 5 cycles (IDLE through WAIT2) and ready=1 in the 6th cycle (DONE).
REQ-021 Write behaviour:
- In LOW: SRAM_DQ = data[15:0], SRAM_WE_N = 0, low address.
- In HIGH: SRAM_DQ = data[31:16], SRAM_WE_N = 0, high address.
- All other states: SRAM_WE_N = 1 and SRAM_DQ high-Z.
REQ-022 Read behaviour: SRAM_DQ SHALL be high-Z. read_data[15:0] SHALL be registered at the end of LOW and read_data[31:16] at the end of HIGH. read_data SHALL hold until the next read capture.
REQ-023 SRAM_ADDR SHALL be registered and SHALL hold its last value in WAIT1, WAIT2, DONE and IDLE.
REQ-024 A request still asserted in DONE SHALL be treated as consumed. A request present in the following IDLE SHALL start a new access, so back-to-back accesses are 6 cycles apart.
REQ-025 Request inputs changing outside IDLE SHALL be ignored.

Reset
REQ-026 When rst=0, the block SHALL force:
- state = IDLE, read_data = 0, SRAM_ADDR = 0;
- SRAM_WE_N = 1, SRAM_DQ high-Z;
- all latched request registers cleared.
REQ-027 Reset mid-access SHALL abort the access without a further write strobe; a partially written word is not restored.

Configuration
REQ-028 With macro SRAM_WAIT_STATES_EN defined, WAIT1 and WAIT2 SHALL exist and access latency is as in REQ-020.
REQ-029 Without SRAM_WAIT_STATES_EN, HIGH SHALL go directly to DONE: ready=0 for 3 cycles and ready=1 in the 4th; all other behaviour is unchanged.

Verification
REQ-030 Write 0xDEADBEEF to address 1024 → SRAM halfword 0 = 0xBEEF, halfword 1 = 0xDEAD; WE_N low for exactly 2 cycles; ready low for 5 cycles, then high for 1.
REQ-031 Read address 1024 after REQ-030 → read_data = 0xDEADBEEF with ready=1 in cycle 6; SRAM_DQ never driven by the block.
REQ-032 Write 0x12345678 to address 1028, then immediately read 1028 → second access starts the cycle after DONE; SRAM_ADDR = 2 then 3; read_data = 0x12345678.
REQ-033 rd_en=1 and wr_en=1 together, address 1032, data 0xA5A5 → write is performed (halfwords 4/5 = 0xA5A5/0x0000); read_data is unchanged.
REQ-034 rst pulsed low during HIGH of a write → state = IDLE, WE_N = 1, DQ = Z, ready = 1 next cycle with no request present.
REQ-035 Build without SRAM_WAIT_STATES_EN; write and read 0xCAFEF00D at 1040 → ready low for 3 cycles per access; data round-trips intact.
